// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - divisor/control inputs and tick outputs of the fractional baud generator
interface baud_gen_frac_if #(
   parameter int DW = 16,
   parameter int FW = 4
);
   logic          en;
   logic          sync;
   logic          load;
   logic [DW-1:0] dvsr_int;
   logic [FW-1:0] dvsr_frac;
   logic          tick;
   logic          bit_tick;
   logic          upd_pending;

   modport master (
      output en, sync, load, dvsr_int, dvsr_frac,
      input  tick, bit_tick, upd_pending
   );

   modport slave (
      input  en, sync, load, dvsr_int, dvsr_frac,
      output tick, bit_tick, upd_pending
   );
endinterface

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with shadowed divisor and bit strobe
module baud_gen_frac #(
   parameter int DW      = 16,
   parameter int FW      = 4,
   parameter int OVS     = 16,
   parameter int RST_DIV = 650
) (
   input logic            clk,
   input logic            reset,
   baud_gen_frac_if.slave bus
);
   localparam int SCW = (OVS > 1) ? $clog2(OVS) : 1;
   localparam logic [SCW-1:0] SC_LAST = SCW'(OVS - 1);
   localparam logic [DW-1:0]  DIV_RST = DW'(RST_DIV);

   logic [DW-1:0]  div_i;
   logic [DW-1:0]  sh_i;
   logic [FW-1:0]  div_f;
   logic [FW-1:0]  sh_f;
   logic [FW-1:0]  acc;
   logic           c;
   logic           pend;
   logic [DW:0]    cnt;
   logic [DW:0]    limit;
   logic [SCW-1:0] sc;
   logic           tick_q;
   logic           bit_tick_q;
   logic           wrap;
   logic           apply;
   logic [FW:0]    acc_sum;

   // One extra bit so a carry on the largest divisor still fits.
   assign limit   = {1'b0, div_i} + {{DW{1'b0}}, c};
   assign wrap    = bus.en && (cnt >= limit);
   assign acc_sum = {1'b0, acc} + {1'b0, div_f};
   // A load on this edge replaces the shadow, so nothing is applied until a later edge.
   assign apply   = pend && !bus.load;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_i      <= DIV_RST;
         div_f      <= '0;
         sh_i       <= '0;
         sh_f       <= '0;
         cnt        <= '0;
         acc        <= '0;
         c          <= 1'b0;
         sc         <= '0;
         pend       <= 1'b0;
         tick_q     <= 1'b0;
         bit_tick_q <= 1'b0;
      end else if (bus.sync) begin
         cnt        <= '0;
         acc        <= '0;
         c          <= 1'b0;
         sc         <= '0;
         tick_q     <= 1'b0;
         bit_tick_q <= 1'b0;
         if (pend) begin
            div_i <= sh_i;
            div_f <= sh_f;
         end
         if (bus.load) begin
            sh_i <= bus.dvsr_int;
            sh_f <= bus.dvsr_frac;
         end
         pend <= bus.load;
      end else begin
         tick_q     <= wrap;
         bit_tick_q <= wrap && (sc == SC_LAST);
         if (bus.load) begin
            sh_i <= bus.dvsr_int;
            sh_f <= bus.dvsr_frac;
            pend <= 1'b1;
         end
         if (!bus.en) begin
            // Idle is a safe boundary: switch divisor right away and restart the period.
            if (apply) begin
               div_i <= sh_i;
               div_f <= sh_f;
               cnt   <= '0;
               acc   <= '0;
               c     <= 1'b0;
               pend  <= 1'b0;
            end
         end else if (!wrap) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt      <= '0;
            {c, acc} <= acc_sum;
            sc       <= (sc == SC_LAST) ? '0 : sc + 1'b1;
            if (apply) begin
               div_i <= sh_i;
               div_f <= sh_f;
               pend  <= 1'b0;
            end
         end
      end
   end

   assign bus.tick        = tick_q;
   assign bus.bit_tick    = bit_tick_q;
   assign bus.upd_pending = pend;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;
   localparam int DW      = 16;
   localparam int FW      = 4;
   localparam int OVS     = 16;
   localparam int RST_DIV = 650;
   localparam int FS      = 1 << FW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   baud_gen_frac_if #(.DW(DW), .FW(FW)) bus ();

   baud_gen_frac #(.DW(DW), .FW(FW), .OVS(OVS), .RST_DIV(RST_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int edge_no = 0;

   // Reference: counts down the enabled edges left in the current period.
   longint m_n, m_f, m_sh_n, m_sh_f, m_left;
   int     m_frac, m_ticks;
   bit     m_pend, m_tick, m_bit;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
      end
   endtask

   task automatic model_edge();
      longint sum;
      bit     can_apply;
      m_tick = 1'b0;
      m_bit  = 1'b0;
      if (reset) begin
         m_n = RST_DIV; m_f = 0; m_pend = 0; m_left = RST_DIV + 1;
         m_frac = 0; m_ticks = 0;
         return;
      end
      if (bus.sync) begin
         if (m_pend) begin m_n = m_sh_n; m_f = m_sh_f; end
         m_pend = 0;
         m_left = m_n + 1; m_frac = 0; m_ticks = 0;
         if (bus.load) begin
            m_sh_n = longint'(bus.dvsr_int); m_sh_f = longint'(bus.dvsr_frac); m_pend = 1;
         end
         return;
      end
      can_apply = m_pend && !bus.load;
      if (bus.load) begin
         m_sh_n = longint'(bus.dvsr_int); m_sh_f = longint'(bus.dvsr_frac); m_pend = 1;
      end
      if (!bus.en) begin
         if (can_apply) begin
            m_n = m_sh_n; m_f = m_sh_f; m_pend = 0; m_left = m_n + 1; m_frac = 0;
         end
         return;
      end
      m_left--;
      if (m_left == 0) begin
         m_tick  = 1'b1;
         m_bit   = (m_ticks == OVS - 1);
         m_ticks = (m_ticks + 1) % OVS;
         sum     = m_frac + m_f;
         m_frac  = int'(sum % FS);
         if (can_apply) begin m_n = m_sh_n; m_f = m_sh_f; m_pend = 0; end
         m_left  = m_n + 1 + ((sum >= FS) ? 1 : 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      edge_no++;
      check_val("tick", bus.tick, m_tick);
      check_val("bit_tick", bus.bit_tick, m_bit);
      check_val("upd_pending", bus.upd_pending, m_pend);
   endtask

   task automatic wait_tick(input int bound, output int at, output bit bt);
      at = -1;
      bt = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (bus.tick) begin
            at = edge_no;
            bt = bus.bit_tick;
            return;
         end
      end
   endtask

   task automatic set_div_idle(input int n, input int f);
      bus.en = 1'b0; bus.load = 1'b1; bus.dvsr_int = DW'(n); bus.dvsr_frac = FW'(f);
      step();
      check_val("pend_after_load", bus.upd_pending, 1);
      bus.load = 1'b0;
      step();
      check_val("pend_after_apply", bus.upd_pending, 0);
   endtask

   initial begin
      int at, at1, at2, cnt_t, cnt_b, first_bit, tick_idx;
      bit bt;
      int exp_frac[5] = '{5, 10, 16, 21, 27};
      int exp_mid[3]  = '{10, 14, 18};

      reset = 1'b1;
      bus.en = 1'b1; bus.sync = 1'b0; bus.load = 1'b0;
      bus.dvsr_int = '0; bus.dvsr_frac = '0;
      step();
      check_val("rst_tick", bus.tick, 0);
      check_val("rst_bit_tick", bus.bit_tick, 0);
      check_val("rst_pending", bus.upd_pending, 0);
      reset = 1'b0;

      // Reset divisor: ticks on edges 651, 1302, 1953; first bit strobe at 10416
      edge_no = 0;
      wait_tick(700, at, bt); check_val("rst_tick_1", at, 651);
      wait_tick(700, at, bt); check_val("rst_tick_2", at, 1302);
      wait_tick(700, at, bt); check_val("rst_tick_3", at, 1953);
      cnt_t = 3; first_bit = -1;
      for (int i = 0; i < 9000 && first_bit < 0; i++) begin
         step();
         if (bus.tick) cnt_t++;
         if (bus.bit_tick) first_bit = edge_no;
      end
      check_val("rst_first_bit_tick", first_bit, 10416);
      check_val("rst_bit_tick_index", cnt_t, 16);

      // N=4, F=8: periods 5,5,6,5,6
      set_div_idle(4, 8);
      bus.en = 1'b1; edge_no = 0;
      foreach (exp_frac[k]) begin
         wait_tick(10, at, bt);
         check_val($sformatf("frac_tick_%0d", k), at, exp_frac[k]);
      end

      // N=0, F=0: tick every cycle, bit strobe every 16th
      set_div_idle(0, 0);
      bus.en = 1'b1; cnt_t = 0; cnt_b = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus.tick) cnt_t++;
         if (bus.bit_tick) cnt_b++;
      end
      check_val("n0_tick_count", cnt_t, 32);
      check_val("n0_bit_count", cnt_b, 2);

      // Load N=3 mid-period at N=9: applied at the wrap, then 4-cycle periods
      set_div_idle(9, 0);
      bus.en = 1'b1; edge_no = 0;
      repeat (4) step();
      bus.load = 1'b1; bus.dvsr_int = 16'd3; bus.dvsr_frac = '0;
      step();
      bus.load = 1'b0;
      check_val("mid_pend_set", bus.upd_pending, 1);
      foreach (exp_mid[k]) begin
         wait_tick(20, at, bt);
         check_val($sformatf("mid_tick_%0d", k), at, exp_mid[k]);
         if (k == 0) check_val("mid_pend_clear", bus.upd_pending, 0);
      end

      // en low for 7 cycles at cnt=3 delays the tick by 7
      set_div_idle(9, 0);
      bus.en = 1'b1; edge_no = 0;
      repeat (3) step();
      bus.en = 1'b0;
      repeat (7) step();
      bus.en = 1'b1;
      wait_tick(20, at, bt);
      check_val("en_gap_tick", at, 17);

      // sync at cnt=5, sc=7
      for (int k = 0; k < 40 && m_ticks != 7; k++) wait_tick(20, at, bt);
      repeat (5) step();
      bus.sync = 1'b1;
      step();
      bus.sync = 1'b0;
      check_val("sync_tick_low", bus.tick, 0);
      check_val("sync_bit_low", bus.bit_tick, 0);
      edge_no = 0;
      wait_tick(20, at, bt);
      check_val("sync_next_tick", at, 10);
      tick_idx = 1; first_bit = bt ? at : -1;
      for (int k = 0; k < 20 && first_bit < 0; k++) begin
         wait_tick(20, at, bt);
         tick_idx++;
         if (bt) first_bit = at;
      end
      check_val("sync_bit_edge", first_bit, 160);
      check_val("sync_bit_index", tick_idx, 16);

      // Largest divisor with carry set: 65537-cycle period, no overflow
      set_div_idle(0, 15);
      bus.en = 1'b1;
      repeat (5) step();
      bus.load = 1'b1; bus.dvsr_int = 16'hFFFF; bus.dvsr_frac = 4'hF;
      step();
      bus.load = 1'b0;
      edge_no = 0;
      wait_tick(10, at1, bt);
      wait_tick(70000, at2, bt);
      check_val("max_period", (at1 < 0 || at2 < 0) ? -1 : at2 - at1, 65537);

      // Randomized traffic against the reference
      set_div_idle(3, 5);
      for (int i = 0; i < 6000; i++) begin
         reset        = ($urandom_range(0, 1999) == 0);
         bus.en       = ($urandom_range(0, 9) != 0);
         bus.sync     = ($urandom_range(0, 99) == 0);
         bus.load     = ($urandom_range(0, 29) == 0);
         bus.dvsr_int = DW'($urandom_range(0, 12));
         bus.dvsr_frac = FW'($urandom_range(0, FS - 1));
         step();
      end
      reset = 1'b0; bus.sync = 1'b0; bus.load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
